// File: rtl/bgr_startup_pkg.sv
// ============================================================================
// Module      : bgr_startup_pkg
// Description : Shared types and helpers for the bandgap start-up sequencer.
//               Holds the FSM state encoding (fixed, visible on state_dbg)
//               and the counter-width helper used to size internal timers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bgr_startup_pkg;

    // Width of the state register and of the state_dbg port.
    localparam int STATE_W = 3;

    // Encodings are fixed because downstream debug tooling decodes state_dbg.
    // Codes 6 and 7 are unused and recover to IDLE.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_KICK   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_QUAL   = 3'd3,
        ST_READY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    // Width of a counter that runs from 0 up to limit-1. Never returns 0 so a
    // limit of 1 still produces a legal one-bit vector.
    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage : bgr_startup_pkg

`default_nettype wire

// File: rtl/bgr_sync2.sv
// ============================================================================
// Module      : bgr_sync2
// Description : Two-flop synchroniser for a single asynchronous level.
//               Asynchronous active-low reset clears both stages to 0, so the
//               synchronised level reads "not ok" until two edges after
//               reset release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bgr_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : bgr_sync2

`default_nettype wire

// File: rtl/bgr_startup_ctrl.sv
// ============================================================================
// Module      : bgr_startup_ctrl
// Description : Start-up sequencer for the bandgap reference. Pulses porst to
//               kick the core out of its zero-current state, qualifies the
//               synchronised bg_ok comparator flag with a consecutive-sample
//               filter, re-kicks on settle timeout and reports ready/fault.
//               All outputs are registered from the next-state decode so each
//               one changes on the same edge that enters its state.
// Options     : BGR_STARTUP_LOSS_MON_EN - when defined, READY watches ok and
//               re-kicks the core after OK_FILT consecutive not-ok samples.
//               When undefined, READY is terminal until en drops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bgr_startup_ctrl
    import bgr_startup_pkg::*;
#(
    parameter int PULSE_CYC  = 16,
    parameter int SETTLE_CYC = 1024,
    parameter int OK_FILT    = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           bg_ok_async,
    output logic                           porst,
    output logic                           ready,
    output logic                           fault,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
    output logic [STATE_W-1:0]             state_dbg
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int PW = cnt_w(PULSE_CYC);
    localparam int SW = cnt_w(SETTLE_CYC);
    localparam int FW = cnt_w(OK_FILT);
    localparam int RW = $clog2(MAX_RETRY + 1);

    localparam logic [PW-1:0] c_pulse_last  = PW'(PULSE_CYC - 1);
    localparam logic [SW-1:0] c_settle_last = SW'(SETTLE_CYC - 1);
    localparam logic [FW-1:0] c_filt_last   = FW'(OK_FILT - 1);
    localparam logic [FW-1:0] c_filt_one    = FW'(1);
    localparam logic [RW-1:0] c_retry_max   = RW'(MAX_RETRY);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic          w_ok_s;

    state_t        r_state;
    logic          r_porst;
    logic          r_ready;
    logic          r_fault;
    logic [RW-1:0] r_retry;
    logic [PW-1:0] r_pulse;
    logic [SW-1:0] r_settle;
    logic [FW-1:0] r_filt;

    state_t        w_state_nxt;
    logic [RW-1:0] w_retry_nxt;
    logic [PW-1:0] w_pulse_nxt;
    logic [SW-1:0] w_settle_nxt;
    logic [FW-1:0] w_filt_nxt;
    logic          w_retry_req;

`ifdef BGR_STARTUP_LOSS_MON_EN
    logic [FW-1:0] r_loss;
    logic [FW-1:0] w_loss_nxt;
`endif

    // ------------------------------------------------------------------------
    // Comparator flag synchroniser; only the synchronised level is used.
    // ------------------------------------------------------------------------
    bgr_sync2 u_ok_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bg_ok_async),
        .o_q   (w_ok_s)
    );

    // ------------------------------------------------------------------------
    // Next-state and counter decode. The retry decision is resolved in the
    // same cycle as the timeout so no extra state is spent on it.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_retry_nxt  = r_retry;
        w_pulse_nxt  = r_pulse;
        w_settle_nxt = r_settle;
        w_filt_nxt   = r_filt;
        w_retry_req  = 1'b0;
`ifdef BGR_STARTUP_LOSS_MON_EN
        // Loss count is only meaningful while in READY; cleared everywhere else.
        w_loss_nxt   = '0;
`endif

        case (r_state)
            ST_IDLE: begin
                w_pulse_nxt  = '0;
                w_settle_nxt = '0;
                w_filt_nxt   = '0;
                if (en) begin
                    w_state_nxt = ST_KICK;
                    w_retry_nxt = '0;
                end
            end

            ST_KICK: begin
                if (r_pulse == c_pulse_last) begin
                    w_state_nxt  = ST_SETTLE;
                    w_settle_nxt = '0;
                    w_filt_nxt   = '0;
                end else begin
                    w_pulse_nxt = r_pulse + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (r_settle != c_settle_last) begin
                    w_settle_nxt = r_settle + 1'b1;
                end
                if (r_settle == c_settle_last) begin
                    w_retry_req = 1'b1;
                end else if (w_ok_s) begin
                    w_state_nxt = ST_QUAL;
                    w_filt_nxt  = c_filt_one;
                end
            end

            ST_QUAL: begin
                // The settle window keeps running across SETTLE/QUAL bounces.
                if (r_settle != c_settle_last) begin
                    w_settle_nxt = r_settle + 1'b1;
                end
                // Completion has priority over a coincident timeout.
                if (w_ok_s && (r_filt == c_filt_last)) begin
                    w_state_nxt = ST_READY;
                end else if (r_settle == c_settle_last) begin
                    w_retry_req = 1'b1;
                end else if (!w_ok_s) begin
                    w_state_nxt = ST_SETTLE;
                    w_filt_nxt  = '0;
                end else begin
                    w_filt_nxt = r_filt + 1'b1;
                end
            end

            ST_READY: begin
`ifdef BGR_STARTUP_LOSS_MON_EN
                // Consecutive not-ok samples; a single ok sample restarts it.
                if (!w_ok_s) begin
                    if (r_loss == c_filt_last) begin
                        w_state_nxt = ST_KICK;
                        w_retry_nxt = '0;
                        w_pulse_nxt = '0;
                    end else begin
                        w_loss_nxt = r_loss + 1'b1;
                    end
                end
`endif
            end

            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Timeout: re-kick while retries remain, otherwise give up.
        if (w_retry_req) begin
            if (r_retry < c_retry_max) begin
                w_state_nxt = ST_KICK;
                w_retry_nxt = r_retry + 1'b1;
                w_pulse_nxt = '0;
            end else begin
                w_state_nxt = ST_FAULT;
            end
        end

        // Dropping en aborts everything, truncating an in-flight kick.
        if (!en) begin
            w_state_nxt  = ST_IDLE;
            w_pulse_nxt  = '0;
            w_settle_nxt = '0;
            w_filt_nxt   = '0;
`ifdef BGR_STARTUP_LOSS_MON_EN
            w_loss_nxt   = '0;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // State, counter and output registers; outputs decode the next state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_porst  <= 1'b0;
            r_ready  <= 1'b0;
            r_fault  <= 1'b0;
            r_retry  <= '0;
            r_pulse  <= '0;
            r_settle <= '0;
            r_filt   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_porst  <= (w_state_nxt == ST_KICK);
            r_ready  <= (w_state_nxt == ST_READY);
            r_fault  <= (w_state_nxt == ST_FAULT);
            r_retry  <= w_retry_nxt;
            r_pulse  <= w_pulse_nxt;
            r_settle <= w_settle_nxt;
            r_filt   <= w_filt_nxt;
        end
    end

`ifdef BGR_STARTUP_LOSS_MON_EN
    // Loss counter register, present only with the loss monitor built in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss <= '0;
        end else begin
            r_loss <= w_loss_nxt;
        end
    end
`endif

    assign porst     = r_porst;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;
    assign state_dbg = r_state;

endmodule : bgr_startup_ctrl

`default_nettype wire

// File: tb/tb_bgr_startup_ctrl.sv
// ============================================================================
// Module      : tb_bgr_startup_ctrl
// Description : Directed self-checking bench for bgr_startup_ctrl at default
//               parameters. Edge numbering inside each scenario: inputs are
//               changed just after edge 0, so edge 1 is the first edge that
//               samples the new value. Loss-monitor scenario follows
//               BGR_STARTUP_LOSS_MON_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bgr_startup_ctrl;

    logic       clk         = 1'b0;
    logic       rst_n       = 1'b0;
    logic       en          = 1'b0;
    logic       bg_ok_async = 1'b0;
    logic       porst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    bgr_startup_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bg_ok_async (bg_ok_async),
        .porst       (porst),
        .ready       (ready),
        .fault       (fault),
        .retry_cnt   (retry_cnt),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    // Advance one active edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; bg_ok_async = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({porst, ready, fault} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: porst/ready/fault=%b expected 000", {porst, ready, fault});
        end
        n_checks++;
        if (retry_cnt !== 2'd0 || state_dbg !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: retry=%0d state=%0d expected 0 0", retry_cnt, state_dbg);
        end
        rst_n = 1'b1;
        repeat (4) step();
        n_checks++;
        if (state_dbg !== 3'd0 || porst !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: state=%0d porst=%b expected 0 0", state_dbg, porst);
        end
    endtask

    task automatic test_clean_start();
        logic       exp_porst, exp_ready;
        logic [2:0] exp_state;
        en = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            step();
            exp_porst = (e <= 16);
            exp_ready = (e >= 25);
            exp_state = (e <= 16) ? 3'd1 : (e == 17) ? 3'd2 : (e <= 24) ? 3'd3 : 3'd4;
            n_checks++;
            if (porst !== exp_porst || ready !== exp_ready || state_dbg !== exp_state) begin
                n_fail++;
                $display("FAIL clean_edge%0d: porst=%b ready=%b state=%0d expected %b %b %0d",
                         e, porst, ready, state_dbg, exp_porst, exp_ready, exp_state);
            end
        end
        n_checks++;
        if (retry_cnt !== 2'd0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL clean_status: retry=%0d fault=%b expected 0 0", retry_cnt, fault);
        end
        en = 1'b0;
        step();
        n_checks++;
        if (ready !== 1'b0 || state_dbg !== 3'd0) begin
            n_fail++; $display("FAIL clean_en_off: ready=%b state=%0d expected 0 0", ready, state_dbg);
        end
    endtask

    // Ok glitch during qualification, then READY is entered (used by loss tests).
    task automatic test_glitchy();
        bg_ok_async = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (17) step();
        n_checks++;
        if (state_dbg !== 3'd2) begin
            n_fail++; $display("FAIL glitch_settle: state=%0d expected 2", state_dbg);
        end
        bg_ok_async = 1'b1;
        repeat (5) begin
            step();
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++; $display("FAIL glitch_high5: ready=%b expected 0", ready);
            end
        end
        bg_ok_async = 1'b0;
        step();
        bg_ok_async = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++; $display("FAIL glitch_requal%0d: ready=%b expected 0", k, ready);
            end
        end
        step();
        n_checks++;
        if (ready !== 1'b1 || state_dbg !== 3'd4 || retry_cnt !== 2'd0) begin
            n_fail++; $display("FAIL glitch_ready: ready=%b state=%0d retry=%0d expected 1 4 0",
                               ready, state_dbg, retry_cnt);
        end
    endtask

`ifdef BGR_STARTUP_LOSS_MON_EN
    task automatic test_loss_monitor();
        bg_ok_async = 1'b0;
        repeat (7) step();
        bg_ok_async = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (ready !== 1'b1 || porst !== 1'b0) begin
                n_fail++; $display("FAIL loss7_%0d: ready=%b porst=%b expected 1 0", k, ready, porst);
            end
        end
        bg_ok_async = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++; $display("FAIL loss8_wait%0d: ready=%b expected 1", k, ready);
            end
        end
        step();
        n_checks++;
        if (ready !== 1'b0 || porst !== 1'b1 || state_dbg !== 3'd1 || retry_cnt !== 2'd0) begin
            n_fail++; $display("FAIL loss8_kick: ready=%b porst=%b state=%0d retry=%0d expected 0 1 1 0",
                               ready, porst, state_dbg, retry_cnt);
        end
        bg_ok_async = 1'b1;
        for (int k = 2; k <= 16; k++) begin
            step();
            n_checks++;
            if (porst !== 1'b1) begin
                n_fail++; $display("FAIL loss_pulse%0d: porst=%b expected 1", k, porst);
            end
        end
        step();
        n_checks++;
        if (porst !== 1'b0 || state_dbg !== 3'd2) begin
            n_fail++; $display("FAIL loss_pulse_end: porst=%b state=%0d expected 0 2", porst, state_dbg);
        end
        repeat (7) step();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL loss_requal_early: ready=%b expected 0", ready);
        end
        step();
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++; $display("FAIL loss_requal: ready=%b expected 1", ready);
        end
    endtask
`else
    task automatic test_loss_monitor();
        bg_ok_async = 1'b0;
        for (int k = 0; k < 100; k++) begin
            step();
            n_checks++;
            if (ready !== 1'b1 || porst !== 1'b0 || state_dbg !== 3'd4) begin
                n_fail++; $display("FAIL noloss_%0d: ready=%b porst=%b state=%0d expected 1 0 4",
                                   k, ready, porst, state_dbg);
            end
        end
        bg_ok_async = 1'b1;
    endtask
`endif

    task automatic test_stuck_low();
        int  rises[$];
        int  widths[$];
        int  wcur;
        logic prev;
        en = 1'b0; bg_ok_async = 1'b0;
        repeat (3) step();
        en = 1'b1;
        prev = 1'b0; wcur = 0;
        for (int e = 1; e <= 4165; e++) begin
            step();
            if (porst && !prev) rises.push_back(e);
            if (porst) wcur++;
            if (!porst && prev) begin widths.push_back(wcur); wcur = 0; end
            prev = porst;
            if (e == 4160) begin
                n_checks++;
                if (fault !== 1'b0) begin
                    n_fail++; $display("FAIL stuck_fault_early: fault=%b expected 0", fault);
                end
            end
            if (e == 4161) begin
                n_checks++;
                if (fault !== 1'b1) begin
                    n_fail++; $display("FAIL stuck_fault_edge: fault=%b expected 1", fault);
                end
            end
        end
        n_checks++;
        if (rises.size() != 4 || widths.size() != 4) begin
            n_fail++; $display("FAIL stuck_kicks: rises=%0d widths=%0d expected 4 4", rises.size(), widths.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (rises[i] != 1 + 1040 * i || widths[i] != 16) begin
                    n_fail++; $display("FAIL stuck_kick%0d: edge=%0d width=%0d expected %0d 16",
                                       i, rises[i], widths[i], 1 + 1040 * i);
                end
            end
        end
        n_checks++;
        if (retry_cnt !== 2'd3 || porst !== 1'b0 || state_dbg !== 3'd5) begin
            n_fail++; $display("FAIL stuck_final: retry=%0d porst=%b state=%0d expected 3 0 5",
                               retry_cnt, porst, state_dbg);
        end
        en = 1'b0;
        step();
        n_checks++;
        if (fault !== 1'b0 || state_dbg !== 3'd0) begin
            n_fail++; $display("FAIL stuck_clear: fault=%b state=%0d expected 0 0", fault, state_dbg);
        end
    endtask

    task automatic test_en_drop();
        en = 1'b1;
        repeat (10) step();
        n_checks++;
        if (porst !== 1'b1 || state_dbg !== 3'd1) begin
            n_fail++; $display("FAIL endrop_kick: porst=%b state=%0d expected 1 1", porst, state_dbg);
        end
        en = 1'b0;
        step();
        n_checks++;
        if (porst !== 1'b0 || state_dbg !== 3'd0) begin
            n_fail++; $display("FAIL endrop_abort: porst=%b state=%0d expected 0 0", porst, state_dbg);
        end
    endtask

    task automatic test_async_reset();
        bit found = 1'b0;
        bg_ok_async = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 1200 && !found; k++) begin
            step();
            if (retry_cnt == 2'd1 && state_dbg == 3'd2) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL areset_reach: retry=%0d state=%0d expected 1 2", retry_cnt, state_dbg);
        end
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({porst, ready, fault} !== 3'b000 || retry_cnt !== 2'd0 || state_dbg !== 3'd0) begin
            n_fail++; $display("FAIL areset_now: flags=%b retry=%0d state=%0d expected 000 0 0",
                               {porst, ready, fault}, retry_cnt, state_dbg);
        end
        en = 1'b0;
        #2;
        rst_n = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_clean_start();
        test_glitchy();
        test_loss_monitor();
        en = 1'b0;
        step();
        test_stuck_low();
        test_en_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_bgr_startup_ctrl

`default_nettype wire

// File: doc/bgr_startup_ctrl.md
Name: bgr_startup_ctrl

Overview:
- Digital start-up sequencer for the bandgap reference; sits directly upstream of the bandgap top and drives its `porst` start-up pin (gate of the NMOS pull-down on node vc).
- Kicks the core out of the zero-current state and qualifies a comparator flag `bg_ok` indicating vbg is in range.
- Retries on timeout and reports `ready`/`fault` to downstream consumers of vbg (ADC, LDO enables).

Parameters:
- PULSE_CYC, 16, porst high width per kick, in clk cycles (≥1).
- SETTLE_CYC, 1024, cycles allowed after kick release to reach qualified ok (≥OK_FILT+2).
- OK_FILT, 8, consecutive synced ok samples required to declare ready; also consecutive not-ok samples that declare loss.
- MAX_RETRY, 3, re-kicks allowed after the first kick before fault.

Ports:
- clk  in  1  sequencer clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start request; level-sensitive
- bg_ok_async  in  1  analog comparator output, asynchronous to clk
- porst  out  1  start-up kick to bandgap top, active high
- ready  out  1  vbg qualified
- fault  out  1  sticky start-up failure
- retry_cnt  out  $clog2(MAX_RETRY+1)  re-kicks issued in current attempt
- state_dbg  out  3  current state encoding

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`rst_n`, clock `clk`). On assertion, immediately and asynchronously: state=IDLE, porst=0, ready=0, fault=0, retry_cnt=0, all counters 0.
- Synchronisation: bg_ok_async passes through a 2-flop synchroniser; ok_s lags the input by 2 edges. Only ok_s is used.
- Outputs are registered from next-state, so each output changes on the same edge that enters its state.
- State IDLE:
  - porst=0, ready=0.
  - en=1 → KICK, retry_cnt←0, fault←0.
- State KICK:
  - porst=1 for exactly PULSE_CYC cycles, then → SETTLE.
  - Settle timer is cleared on entry to SETTLE.
- State SETTLE:
  - Settle timer increments each cycle.
  - ok_s=1 → QUAL with filter=1.
  - Timer reaches SETTLE_CYC-1 → RETRY decision.
- State QUAL:
  - Settle timer keeps running (not reset).
  - ok_s=1 → filter++. filter==OK_FILT-1 with ok_s=1 → READY.
  - ok_s=0 → SETTLE with filter=0.
  - If timeout and completion coincide, READY wins.
- RETRY decision (combinational, no extra cycle):
  - retry_cnt<MAX_RETRY → retry_cnt++, → KICK.
  - Otherwise → FAULT.
- State READY:
  - ready=1; retry_cnt holds its value.
  - Loss behaviour per optional feature.
- State FAULT:
  - fault=1, porst=0, ready=0.
  - Exits only on en=0.
- en=0 in any state → IDLE on the next edge; porst, ready and fault clear on that edge. An in-flight kick pulse is truncated.
- en re-asserted while in IDLE → fresh sequence; retry_cnt is cleared.
- Counters are sized $clog2 of their limit and never wrap; they are cleared on state entry.
- Encoding: IDLE=0, KICK=1, SETTLE=2, QUAL=3, READY=4, FAULT=5; 6 and 7 map to IDLE.

Optional Feature:
- Macro: BGR_STARTUP_LOSS_MON_EN.
- Defined:
  - In READY, a loss counter counts consecutive ok_s=0 cycles and resets on ok_s=1.
  - Reaching OK_FILT → ready=0 and → KICK on that edge, with retry_cnt←0.
- Undefined:
  - READY is terminal until en=0; ok_s is ignored in READY.
  - No loss counter is instantiated.

Decomposition:
- Package bgr_startup_pkg: state enum typedef with the fixed encodings, the STATE_W=3 constant, and a localparam function for counter widths.
- Sub-module bgr_sync2: 2-flop synchroniser with async active-low reset to 0; one instance for bg_ok_async.

Test Plan (default parameters, edge 0 = first edge with en=1, bg_ok_async=1 long before):
- Clean start: porst=1 on edges 1–16, SETTLE at 17, QUAL at 18 → ready=1 from edge 25, retry_cnt=0, fault=0.
- bg_ok stuck 0: exactly 4 porst pulses of 16 cycles spaced 1040 cycles apart → fault=1 at edge 4161, retry_cnt=3, porst=0; en=0 → fault=0 next edge.
- Glitchy ok (after kick: 5 cycles high, 1 low, then high): no ready after 5 cycles; ready asserts 8 synced-high cycles after the final rise; no retry issued.
- en dropped on edge 10 (mid-KICK) → porst=0 and state_dbg=0 at edge 11; rst_n low mid-SETTLE → outputs 0 immediately, without waiting for a clock.
- Loss monitor enabled, in READY: ok low 7 cycles → ready stays 1; ok low 8 cycles → ready=0 and porst=1 on the same edge, followed by a 16-cycle pulse and re-qualification.
- Loss monitor disabled: ok low for 100 cycles in READY → ready stays 1, porst stays 0.
